// File: rtl/vc_skid_pkg.sv
// ---------------------------------------------------------------------------
// vc_skid_pkg
//   Shared definitions for the two-entry val/rdy skid register.
//   - VC_SKID_EMPTY / VC_SKID_BUSY / VC_SKID_FULL : 2-bit state encodings
//   - vc_skid_src_e : data source selected in front of the main register
//   - vc_skid_occupancy() : number of held entries for a state encoding
// ---------------------------------------------------------------------------
package vc_skid_pkg;

  localparam logic [1:0] VC_SKID_EMPTY = 2'd0;  // no entries
  localparam logic [1:0] VC_SKID_BUSY  = 2'd1;  // one entry, in main
  localparam logic [1:0] VC_SKID_FULL  = 2'd2;  // main is older, skid is newer

  // Which value gets written into the main register when it is enabled.
  typedef enum logic {
    VC_SKID_SRC_ENQ  = 1'b0,
    VC_SKID_SRC_SKID = 1'b1
  } vc_skid_src_e;

  // Entries held for a given state; the illegal encoding counts as empty.
  function automatic logic [1:0] vc_skid_occupancy(input logic [1:0] state);
    logic [1:0] n;
    n = 2'd0;
    case (state)
      VC_SKID_BUSY: n = 2'd1;
      VC_SKID_FULL: n = 2'd2;
      default:      n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vc_skid_reg_enreg.sv
// ---------------------------------------------------------------------------
// vc_EnReg
//   Plain enable register, no reset. Holds its value unless en is high.
//   Ports:
//     clk  in           clock
//     en   in           load enable
//     d    in  [p_nbits] data in
//     q    out [p_nbits] registered data
// ---------------------------------------------------------------------------
module vc_EnReg #(
  parameter int unsigned p_nbits = 1
) (
  input  logic               clk,
  input  logic               en,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  logic [p_nbits-1:0] data_q;
  logic [p_nbits-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/vc_skid_reg_resetreg.sv
// ---------------------------------------------------------------------------
// vc_ResetReg
//   Register loaded every cycle, forced to p_reset_value by a synchronous,
//   active-high reset.
//   Ports:
//     clk    in            clock
//     reset  in            synchronous reset, active high
//     d      in  [p_nbits] next value
//     q      out [p_nbits] registered value
// ---------------------------------------------------------------------------
module vc_ResetReg #(
  parameter int unsigned          p_nbits       = 1,
  parameter logic [p_nbits-1:0]   p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  logic [p_nbits-1:0] data_q;
  logic [p_nbits-1:0] data_d;

  always_comb begin
    data_d = d;
    if (reset) begin
      data_d = p_reset_value;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/vc_skid_reg.sv
// ---------------------------------------------------------------------------
// vc_skid_reg
//   Two-entry, fully registered val/rdy pipeline stage. Carries messages
//   forward in strict FIFO order and cuts the combinational ready path:
//   deq_val, deq_msg and enq_rdy depend only on flops (and reset).
//
//   Ports:
//     clk      in            clock, rising edge
//     reset    in            synchronous reset, active high
//     enq_val  in            upstream message valid
//     enq_rdy  out           stage can accept a message this cycle
//     enq_msg  in  [p_nbits] upstream message
//     deq_val  out           message presented downstream
//     deq_rdy  in            downstream accepts this cycle
//     deq_msg  out [p_nbits] downstream message (the main register)
//
//   Optional build macro: VC_SKID_ASSERT_EN
//     When defined, simulation assertions check for X on enq_val/deq_rdy
//     outside reset, an enq fire while FULL, and the illegal state 2'd3.
//     When undefined no assertion logic is compiled.
// ---------------------------------------------------------------------------
module vc_skid_reg
  import vc_skid_pkg::*;
#(
  parameter int unsigned p_nbits = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [p_nbits-1:0] main_q;
  logic [p_nbits-1:0] main_d;
  logic [p_nbits-1:0] skid_q;
  logic               main_en;
  logic               skid_en;
  vc_skid_src_e       main_src;
  logic               enq_fire;
  logic               deq_fire;

  // Output decode uses only the state flop and reset, never enq_val/deq_rdy.
  assign deq_val  = (state_q != VC_SKID_EMPTY);
  assign enq_rdy  = (state_q != VC_SKID_FULL) & ~reset;
  assign deq_msg  = main_q;

  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  // Next-state and register-enable logic.
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_src = VC_SKID_SRC_ENQ;
    case (state_q)
      VC_SKID_EMPTY: begin
        if (enq_fire) begin
          state_d = VC_SKID_BUSY;
          main_en = 1'b1;
        end
      end
      VC_SKID_BUSY: begin
        if (enq_fire && deq_fire) begin
          // Pass-through: the outgoing entry is replaced in place.
          main_en = 1'b1;
        end else if (enq_fire) begin
          // Downstream stalled: park the newer entry in skid.
          state_d = VC_SKID_FULL;
          skid_en = 1'b1;
        end else if (deq_fire) begin
          state_d = VC_SKID_EMPTY;
        end
      end
      VC_SKID_FULL: begin
        // enq_rdy is low here, so only the drain path exists.
        if (deq_fire) begin
          state_d  = VC_SKID_BUSY;
          main_en  = 1'b1;
          main_src = VC_SKID_SRC_SKID;
        end
      end
      default: begin
        // Illegal encoding recovers to EMPTY.
        state_d = VC_SKID_EMPTY;
      end
    endcase
  end

  // Data source mux in front of the main register.
  always_comb begin
    main_d = enq_msg;
    if (main_src == VC_SKID_SRC_SKID) begin
      main_d = skid_q;
    end
  end

  vc_ResetReg #(
    .p_nbits       (2),
    .p_reset_value (VC_SKID_EMPTY)
  ) state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_d),
    .q     (state_q)
  );

  vc_EnReg #(
    .p_nbits (p_nbits)
  ) main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  vc_EnReg #(
    .p_nbits (p_nbits)
  ) skid (
    .clk (clk),
    .en  (skid_en),
    .d   (enq_msg),
    .q   (skid_q)
  );

`ifdef VC_SKID_ASSERT_EN
`ifndef VC_ASSERT_NOT_X
`define VC_ASSERT_NOT_X(sig) assert (!$isunknown(sig)) else $error("vc_skid_reg: X on sig")
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      `VC_ASSERT_NOT_X(enq_val);
      `VC_ASSERT_NOT_X(deq_rdy);
      assert (!(enq_fire && (state_q == VC_SKID_FULL)))
        else $error("vc_skid_reg: enq fire while full");
      assert (state_q != 2'd3)
        else $error("vc_skid_reg: illegal state encoding");
      assert (vc_skid_occupancy(state_q) <= 2'd2)
        else $error("vc_skid_reg: occupancy out of range");
    end
  end
`endif

endmodule

// File: tb/tb_vc_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_vc_skid_reg
//   Directed test of vc_skid_reg with p_nbits=8, followed by a randomised
//   run checked against a two-entry FIFO scoreboard.
//   Inputs are driven 1 time unit after each rising edge; outputs are
//   checked at that same point, after they have settled from the edge.
// ---------------------------------------------------------------------------
module tb_vc_skid_reg;

  logic       clk;
  logic       reset;
  logic       enq_val;
  logic       enq_rdy;
  logic [7:0] enq_msg;
  logic       deq_val;
  logic       deq_rdy;
  logic [7:0] deq_msg;

  int checks   = 0;
  int failures = 0;

  vc_skid_reg #(.p_nbits(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_msg),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_msg (deq_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : main_seq
    logic [7:0] sb_q[$];
    logic       e_fire;
    logic       d_fire;
    logic [7:0] got;
    int         deqs;
    int         enqs;

    reset   = 1'b1;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    enq_msg = 8'h00;

    // Reset held for two cycles.
    step();
    step();
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("post_rst_deq_val", 32'(deq_val), 32'd0);
    $display("txn reset released");

    // Single enq then back-to-back stream with deq_rdy held high.
    deq_rdy = 1'b1;
    enq_val = 1'b1;
    enq_msg = 8'h11;
    step();
    chk("lat_deq_val", 32'(deq_val), 32'd1);
    chk("lat_deq_msg", 32'(deq_msg), 32'h11);
    $display("txn enq 0x11 -> deq 0x%02h", deq_msg);
    for (int v = 8'h12; v <= 8'h1F; v++) begin
      enq_msg = 8'(v);
      chk("stream_enq_rdy", 32'(enq_rdy), 32'd1);
      step();
      chk("stream_deq_msg", 32'(deq_msg), 32'(v));
      chk("stream_deq_val", 32'(deq_val), 32'd1);
      $display("txn stream enq 0x%02h -> deq 0x%02h", v[7:0], deq_msg);
    end
    enq_val = 1'b0;
    step();
    chk("stream_drain", 32'(deq_val), 32'd0);

    // Fill to FULL under backpressure, then drain.
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 8'hA0;
    step();
    chk("a_busy_rdy", 32'(enq_rdy), 32'd1);
    chk("a_busy_msg", 32'(deq_msg), 32'hA0);
    enq_msg = 8'hA1;
    step();
    chk("a_full_rdy", 32'(enq_rdy), 32'd0);
    chk("a_full_val", 32'(deq_val), 32'd1);
    chk("a_full_msg", 32'(deq_msg), 32'hA0);
    enq_val = 1'b0;
    step();
    chk("a_hold_msg", 32'(deq_msg), 32'hA0);
    deq_rdy = 1'b1;
    step();
    $display("txn deq 0xA0, now presenting 0x%02h", deq_msg);
    chk("a_drain1_msg", 32'(deq_msg), 32'hA1);
    chk("a_drain1_rdy", 32'(enq_rdy), 32'd1);
    step();
    chk("a_drain2_val", 32'(deq_val), 32'd0);

    // FULL with B0/B1; B2 offered while FULL must wait a cycle.
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 8'hB0;
    step();
    enq_msg = 8'hB1;
    step();
    enq_msg = 8'hB2;
    deq_rdy = 1'b1;
    chk("b_full_rdy", 32'(enq_rdy), 32'd0);
    chk("b_out0", 32'(deq_msg), 32'hB0);
    step();
    chk("b_out1", 32'(deq_msg), 32'hB1);
    chk("b_rdy_back", 32'(enq_rdy), 32'd1);
    step();
    enq_val = 1'b0;
    chk("b_out2", 32'(deq_msg), 32'hB2);
    chk("b_out2_val", 32'(deq_val), 32'd1);
    step();
    chk("b_empty", 32'(deq_val), 32'd0);
    $display("txn order B0 B1 B2 checked");

    // Reset while FULL discards both entries.
    deq_rdy = 1'b0;
    enq_val = 1'b1;
    enq_msg = 8'hB3;
    step();
    enq_msg = 8'hB4;
    step();
    enq_val = 1'b0;
    chk("c_full_rdy", 32'(enq_rdy), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("c_rst_val", 32'(deq_val), 32'd0);
    chk("c_rst_rdy", 32'(enq_rdy), 32'd1);
    enq_val = 1'b1;
    enq_msg = 8'hC5;
    step();
    enq_val = 1'b0;
    chk("c_c5_val", 32'(deq_val), 32'd1);
    chk("c_c5_msg", 32'(deq_msg), 32'hC5);
    deq_rdy = 1'b1;
    step();
    chk("c_no_stale", 32'(deq_val), 32'd0);
    $display("txn reset flush, 0xC5 alone");

    // Random traffic against a two-entry FIFO model.
    deqs = 0;
    enqs = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      enq_val = 1'($urandom_range(0, 1));
      deq_rdy = 1'($urandom_range(0, 1));
      enq_msg = 8'($urandom);
      #1;
      chk("rnd_deq_val", 32'(deq_val), 32'(sb_q.size() != 0));
      chk("rnd_enq_rdy", 32'(enq_rdy), 32'(sb_q.size() < 2));
      e_fire = enq_val && (sb_q.size() < 2);
      d_fire = deq_rdy && (sb_q.size() != 0);
      if (d_fire) begin
        got = sb_q.pop_front();
        chk("rnd_deq_msg", 32'(deq_msg), 32'(got));
        deqs++;
      end
      if (e_fire) begin
        sb_q.push_back(enq_msg);
        enqs++;
      end
      step();
    end
    // Drain whatever the model still holds, bounded.
    enq_val = 1'b0;
    deq_rdy = 1'b1;
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) begin
      chk("drain_deq_val", 32'(deq_val), 32'd1);
      got = sb_q.pop_front();
      chk("drain_deq_msg", 32'(deq_msg), 32'(got));
      deqs++;
      step();
    end
    chk("drain_done", 32'(deq_val), 32'd0);
    chk("rnd_count", 32'(deqs), 32'(enqs));
    $display("txn random run enq=%0d deq=%0d", enqs, deqs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_skid_reg.md
# vc_skid_reg

Two-entry, fully registered val/rdy pipeline stage that carries a message forward and breaks the combinational ready path running backward. It sits between any two val/rdy endpoints in the cache and coherence pipeline, for example cache to memory request or snoop response. In those paths a plain enable register cannot absorb backpressure without losing data. The block presents `deq_val`/`deq_msg` and `enq_rdy` straight from flops.

## Interface
- `p_nbits`, default 1: message width in bits.

Ports (clock and reset first):
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising `clk` edge.
- `enq_val`  input  1  the upstream message is valid.
- `enq_rdy`  output  1  the stage can accept a message this cycle.
- `enq_msg`  input  `p_nbits`  upstream message.
- `deq_val`  output  1  a message is presented downstream.
- `deq_rdy`  input  1  downstream accepts this cycle.
- `deq_msg`  output  `p_nbits`  downstream message; always equals the main register.

## Operation
- Fire conditions:
  - enq fire = `enq_val & enq_rdy`.
  - deq fire = `deq_val & deq_rdy`.
- Storage:
  - main data register `main`, drives `deq_msg`.
  - skid data register `skid`.
  - 2-bit state register.
- States:
  - EMPTY: 0 entries.
  - BUSY: 1 entry, held in `main`.
  - FULL: 2 entries; `main` is older, `skid` is newer.
- Output decode:
  - `deq_val = (state != EMPTY)`.
  - `enq_rdy = (state != FULL) & !reset`.
  - Neither output depends combinationally on `enq_val` or `deq_rdy`.
- Transitions:
  - EMPTY, enq fire → BUSY, `main <= enq_msg`.
  - EMPTY, no enq fire → EMPTY.
  - BUSY, enq fire and deq fire → BUSY, `main <= enq_msg`.
  - BUSY, enq fire only → FULL, `skid <= enq_msg`.
  - BUSY, deq fire only → EMPTY.
  - BUSY, neither fires → BUSY, hold.
  - FULL, deq fire → BUSY, `main <= skid`.
  - FULL, no deq fire → FULL, hold. No enq fire is possible because `enq_rdy=0`.
- Ordering: strict FIFO. No message is dropped, duplicated or reordered.
- Reset:
  - state goes to EMPTY; `deq_val=0`; `enq_rdy=0` while `reset` is high, then 1 on the first cycle after it falls.
  - `main` and `skid` are not reset; `deq_msg` is don't-care while `deq_val=0`.
- Reset mid-operation: all held entries are discarded with no drain.
- Unknown state encoding (2'd3): behaves as EMPTY on the next edge.

## Timing
- Latency: 1 cycle from enq fire to `deq_val` when EMPTY.
- Throughput: 1 message/cycle in steady state (BUSY with both ends firing).
- `enq_rdy` falls 1 cycle after the enq fire that fills the skid register.
- `enq_rdy` rises 1 cycle after the deq fire taken while FULL.
- Sender rule: while `deq_val=1` and `deq_rdy=0`, `deq_msg` and `deq_val` are held stable.
- Upstream may drop `enq_val` at any time. No requirement is placed on upstream stability.

## Configuration
- Macro: `VC_SKID_ASSERT_EN`.
- Defined:
  - when `reset=0`, `VC_ASSERT_NOT_X` checks `enq_val` and `deq_rdy` on every edge.
  - an assertion fires if an enq fire occurs while state is FULL.
  - an assertion fires if the state register holds 2'd3.
- Undefined: no assertion logic is compiled. Functional behaviour is identical.

## Structure
- Package `vc_skid_pkg` holds the state encoding constants:
  - `VC_SKID_EMPTY = 2'd0`
  - `VC_SKID_BUSY = 2'd1`
  - `VC_SKID_FULL = 2'd2`
- Sub-module `vc_EnReg` (width `p_nbits`) is instantiated twice:
  - `main`: enable = load-from-enq or load-from-skid; a 2:1 mux in front selects the data source.
  - `skid`: enable = enq fire in BUSY with no deq fire.
- The state register is a `vc_ResetReg` of width 2.
- Next-state and enable logic live in one combinational block in the top module.

## Test plan
All scenarios use `p_nbits=8`.
- Reset held for 2 cycles, then released → during reset `deq_val=0`, `enq_rdy=0`; on the first cycle after release `enq_rdy=1`, `deq_val=0`.
- Enq 0x11 with `deq_rdy=1` held → `deq_val=1`, `deq_msg=0x11` the next cycle. Then stream 0x12..0x1F back to back → one output per cycle, in order, `enq_rdy` never 0.
- `deq_rdy=0`, enq 0xA0 then 0xA1 → state FULL and `enq_rdy=0` after the 2nd edge; `deq_msg` holds 0xA0. Then `deq_rdy=1` for 2 cycles → 0xA0 then 0xA1 out, `enq_rdy=1` the cycle after the first deq fire.
- FULL with 0xB0/0xB1, then enq 0xB2 presented with simultaneous deq fire → 0xB2 is not accepted that cycle; it is accepted the next cycle; output order is 0xB0, 0xB1, 0xB2.
- FULL, assert `reset` for 1 cycle → `deq_val=0` the next cycle; the subsequent enq 0xC5 appears alone at the output, with no stale 0xB-series data.
- Random `enq_val`/`deq_rdy` at 50% for 1000 cycles against a scoreboard → no loss, no duplication, order preserved. With `VC_SKID_ASSERT_EN` defined, no assertion fires.
